// File: rtl/acc_cpu_pkg.sv
// Shared types and width helpers for the parametrised accumulator core.
// Opcode and state encodings live here so the core and bench agree on them.
package acc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_XOR  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JZ   = 4'h8,
    OP_JC   = 4'h9,
    OP_CALL = 4'hA,
    OP_RET  = 4'hB,
    OP_NOP  = 4'hC
  } opcode_e;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEMWR  = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam int unsigned OPC_W = 4;

  // Instruction word width (IW) for a given address width.
  function automatic int unsigned iw_f(input int unsigned aw);
    return OPC_W + aw;
  endfunction

  // Stack-pointer width (SPW): must count 0..depth inclusive.
  function automatic int unsigned spw_f(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acc_ret_stack.sv
// Hardware return stack for CALL/RET: AW-bit entries, full/empty flags.
// Push while full and pop while empty are ignored; the core traps those cases.
module acc_ret_stack
  import acc_cpu_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned SPW  = spw_f(DEPTH);
  localparam int unsigned PTRW = SPW - 1;

  logic [SPW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_idx_s, rd_idx_s;

  assign full_o   = (cnt_q == SPW'(DEPTH));
  assign empty_o  = (cnt_q == {SPW{1'b0}});
  assign wr_idx_s = cnt_q[PTRW-1:0];
  assign rd_idx_s = cnt_q[PTRW-1:0] - PTRW'(1);
  assign top_o    = mem_q[rd_idx_s];

  // Occupancy count update.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o) begin
      cnt_d = cnt_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - SPW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {SPW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {AW{1'b0}};
      end
    end else begin
      cnt_q <= cnt_d;
      if (push_i && !full_o) begin
        mem_q[wr_idx_s] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: PROM fetch, data-RAM access with wait states,
// Z/C flags, conditional branches and a trapping return stack.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 5,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [AW-1:0]        prom_addr_out,
  output logic                 prom_rd,
  input  logic                 prom_ready,
  input  logic [iw_f(AW)-1:0]  prom_data_in,
  output logic [AW-1:0]        mem_addr_out,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic                 mem_ready,
  input  logic [DW-1:0]        mem_data_in,
  output logic [DW-1:0]        mem_data_out,
  output logic                 zero,
  output logic                 carry,
  output logic                 halted,
  output logic                 stk_err
);

  localparam int unsigned IW = iw_f(AW);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mdr_q, mdr_d;
  logic            z_q, z_d, c_q, c_d;
  logic            prom_rd_q, prom_rd_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            halted_q, halted_d;
  logic            stk_err_q, stk_err_d;

  logic [3:0]      opc_s;
  logic [AW-1:0]   opnd_s;
  logic            push_s, pop_s;
  logic [AW-1:0]   stk_top_s;
  logic            stk_full_s, stk_empty_s;
  logic [DW:0]     sum_s, diff_s;
  logic [DW-1:0]   alu_res_s;
  logic            alu_c_s, alu_wr_s, alu_cw_s;

  assign opc_s  = ir_q[IW-1:AW];
  assign opnd_s = ir_q[AW-1:0];

  acc_ret_stack #(
    .AW    (AW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (pc_q),
    .top_o       (stk_top_s),
    .full_o      (stk_full_s),
    .empty_o     (stk_empty_s)
  );

  // ALU: result, carry/borrow and which of ACC/Z and C the opcode updates.
  always_comb begin
    sum_s     = {1'b0, acc_q} + {1'b0, mdr_q};
    diff_s    = {1'b0, acc_q} - {1'b0, mdr_q};
    alu_res_s = acc_q;
    alu_c_s   = c_q;
    alu_wr_s  = 1'b0;
    alu_cw_s  = 1'b0;
    case (opc_s)
      OP_LDA: begin
        alu_res_s = mdr_q;
        alu_wr_s  = 1'b1;
      end
      OP_ADD: begin
        alu_res_s = sum_s[DW-1:0];
        alu_c_s   = sum_s[DW];
        alu_wr_s  = 1'b1;
        alu_cw_s  = 1'b1;
      end
      // The extra top bit of the difference is the unsigned borrow.
      OP_SUB: begin
        alu_res_s = diff_s[DW-1:0];
        alu_c_s   = diff_s[DW];
        alu_wr_s  = 1'b1;
        alu_cw_s  = 1'b1;
      end
      OP_AND: begin
        alu_res_s = acc_q & mdr_q;
        alu_wr_s  = 1'b1;
      end
      OP_XOR: begin
        alu_res_s = acc_q ^ mdr_q;
        alu_wr_s  = 1'b1;
      end
      default: begin
        alu_res_s = acc_q;
      end
    endcase
  end

  // Next-state, datapath and registered request outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    mdr_d     = mdr_q;
    z_d       = z_q;
    c_d       = c_q;
    stk_err_d = stk_err_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (prom_ready) begin
          ir_d    = prom_data_in;
          pc_d    = pc_q + AW'(1);
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opc_s)
          OP_HLT: state_d = ST_HALT;
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_XOR: state_d = ST_MEMRD;
          OP_STA: state_d = ST_MEMWR;
          OP_JMP: begin
            pc_d    = opnd_s;
            state_d = ST_FETCH;
          end
          OP_JZ: begin
            if (z_q) begin
              pc_d = opnd_s;
            end else begin
              pc_d = pc_q;
            end
            state_d = ST_FETCH;
          end
          OP_JC: begin
            if (c_q) begin
              pc_d = opnd_s;
            end else begin
              pc_d = pc_q;
            end
            state_d = ST_FETCH;
          end
          // A trapped CALL leaves PC pointing past the CALL itself.
          OP_CALL: begin
            if (stk_full_s) begin
              stk_err_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              push_s  = 1'b1;
              pc_d    = opnd_s;
              state_d = ST_FETCH;
            end
          end
          OP_RET: begin
            if (stk_empty_s) begin
              stk_err_d = 1'b1;
              state_d   = ST_HALT;
            end else begin
              pop_s   = 1'b1;
              pc_d    = stk_top_s;
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEMRD: begin
        if (mem_ready) begin
          mdr_d   = mem_data_in;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_MEMRD;
        end
      end
      ST_EXEC: begin
        if (alu_wr_s) begin
          acc_d = alu_res_s;
          z_d   = (alu_res_s == {DW{1'b0}});
        end else begin
          acc_d = acc_q;
        end
        if (alu_cw_s) begin
          c_d = alu_c_s;
        end else begin
          c_d = c_q;
        end
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEMWR;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Requests follow the next state so they are flop outputs, not ready-driven.
    prom_rd_d = (state_d == ST_FETCH);
    mem_rd_d  = (state_d == ST_MEMRD);
    mem_wr_d  = (state_d == ST_MEMWR);
    halted_d  = (state_d == ST_HALT);
  end

  // Core state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= {AW{1'b0}};
      ir_q      <= {IW{1'b0}};
      acc_q     <= {DW{1'b0}};
      mdr_q     <= {DW{1'b0}};
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      prom_rd_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      halted_q  <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      mdr_q     <= mdr_d;
      z_q       <= z_d;
      c_q       <= c_d;
      prom_rd_q <= prom_rd_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      halted_q  <= halted_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign prom_addr_out = pc_q;
  assign prom_rd       = prom_rd_q;
  assign mem_addr_out  = opnd_s;
  assign mem_rd        = mem_rd_q;
  assign mem_wr        = mem_wr_q;
  assign mem_data_out  = acc_q;
  assign zero          = z_q;
  assign carry         = c_q;
  assign halted        = halted_q;
  assign stk_err       = stk_err_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: expected fetch addresses and data writes
// are queued when a program is loaded and popped as the core performs them.
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] prom_addr_out;
  logic          prom_rd;
  logic          prom_ready;
  logic [IW-1:0] prom_data_in;
  logic [AW-1:0] mem_addr_out;
  logic          mem_rd, mem_wr, mem_ready;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          zero, carry, halted, stk_err;

  logic [IW-1:0] prog [32];
  logic [DW-1:0] ram  [32];
  logic          mem_rdy = 1'b1;

  assign prom_ready   = 1'b1;
  assign prom_data_in = prog[prom_addr_out];
  assign mem_data_in  = ram[mem_addr_out];
  assign mem_ready    = mem_rdy;

  acc_cpu_core #(.DW(DW), .AW(AW), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .prom_addr_out(prom_addr_out), .prom_rd(prom_rd), .prom_ready(prom_ready),
    .prom_data_in(prom_data_in),
    .mem_addr_out(mem_addr_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .zero(zero), .carry(carry), .halted(halted), .stk_err(stk_err)
  );

  // Wide build: DW=16, AW=8, both memories zero-wait.
  logic        rst16;
  logic [7:0]  pa16, ma16;
  logic        prd16, mrd16, mwr16;
  logic [11:0] pd16;
  logic [15:0] mdi16, mdo16;
  logic        z16, c16, h16, e16;
  logic [11:0] prog16 [256];
  logic [15:0] ram16  [256];

  assign pd16  = prog16[pa16];
  assign mdi16 = ram16[ma16];

  acc_cpu_core #(.DW(16), .AW(8), .STACK_DEPTH(4)) u16 (
    .clk(clk), .reset(rst16),
    .prom_addr_out(pa16), .prom_rd(prd16), .prom_ready(1'b1), .prom_data_in(pd16),
    .mem_addr_out(ma16), .mem_rd(mrd16), .mem_wr(mwr16), .mem_ready(1'b1),
    .mem_data_in(mdi16), .mem_data_out(mdo16),
    .zero(z16), .carry(c16), .halted(h16), .stk_err(e16)
  );

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_exp [$];
  logic [4:0] fetch_exp [$];
  int         fetch_t [$];
  wr_t        wr_e;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input int a);
    return {op, 5'(a)};
  endfunction

  int         stall_left = 0;
  int         rd_cycles  = 0;
  int         acc_chg    = 0;
  int         cyc_n      = 0;
  logic       prev_rd    = 1'b0;
  logic [4:0] prev_addr  = 5'd0;
  logic [7:0] prev_acc   = 8'd0;

  // Memory models, wait-state injection and scoreboard pops.
  always @(negedge clk) begin
    cyc_n++;
    if (reset) begin
      if ((mem_rd || mem_wr) && stall_left > 0) begin
        mem_rdy = 1'b0;
        stall_left--;
      end else begin
        mem_rdy = 1'b1;
      end
      check("req_onehot", 32'((32'(prom_rd) + 32'(mem_rd) + 32'(mem_wr)) <= 32'd1), 32'd1);
      if (mem_rd) begin
        rd_cycles++;
        if (prev_rd) check("rd_addr_stable", 32'(mem_addr_out), 32'(prev_addr));
      end
      prev_rd   = mem_rd;
      prev_addr = mem_addr_out;
      if (mem_data_out != prev_acc) acc_chg++;
      prev_acc = mem_data_out;
      if (prom_rd && prom_ready) begin
        fetch_t.push_back(cyc_n);
        if (fetch_exp.size() == 0) check("fetch_extra", 32'(prom_addr_out), 32'hFFFF);
        else check("fetch_addr", 32'(prom_addr_out), 32'(fetch_exp.pop_front()));
      end
      if (mem_wr && mem_rdy) begin
        ram[mem_addr_out] = mem_data_out;
        if (wr_exp.size() == 0) check("wr_extra", 32'(mem_addr_out), 32'hFFFF);
        else begin
          wr_e = wr_exp.pop_front();
          check("wr_addr", 32'(mem_addr_out), 32'(wr_e.a));
          check("wr_data", 32'(mem_data_out), 32'(wr_e.d));
        end
      end
    end else begin
      mem_rdy  = 1'b1;
      prev_rd  = 1'b0;
      prev_acc = 8'd0;
    end
  end

  // Wide-build data RAM (writes complete immediately).
  always @(negedge clk) begin
    if (rst16 && mwr16) ram16[ma16] = mdo16;
  end

  task automatic clear_all();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      prog[i] = 9'd0;
      ram[i]  = 8'd0;
    end
    fetch_exp.delete();
    wr_exp.delete();
    fetch_t.delete();
    stall_left = 0;
    rd_cycles  = 0;
    acc_chg    = 0;
  endtask

  task automatic release_rst();
    check("rst_prom_rd", 32'(prom_rd), 32'd0);
    check("rst_pc", 32'(prom_addr_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("first_fetch", 32'(prom_rd), 32'd1);
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic end_chk();
    check("fetch_left", 32'(fetch_exp.size()), 32'd0);
    check("wr_left", 32'(wr_exp.size()), 32'd0);
  endtask

  int n;

  initial begin
    rst16 = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      prog16[i] = 12'd0;
      ram16[i]  = 16'd0;
    end

    // LDA/ADD/STA/HLT: 0xF0+0x20 -> 0x10 with carry, 13 cycles to halt.
    clear_all();
    prog[0] = mk(4'h1, 3); prog[1] = mk(4'h3, 4); prog[2] = mk(4'h2, 5); prog[3] = mk(4'h0, 0);
    ram[3] = 8'hF0; ram[4] = 8'h20;
    fetch_exp = '{5'd0, 5'd1, 5'd2, 5'd3};
    wr_exp.push_back('{a: 5'd5, d: 8'h10});
    release_rst();
    wait_halt(n);
    check("t1_cycles", 32'(n), 32'd13);
    check("t1_carry", 32'(carry), 32'd1);
    check("t1_zero", 32'(zero), 32'd0);
    check("t1_acc", 32'(mem_data_out), 32'h10);
    check("t1_stk_err", 32'(stk_err), 32'd0);
    end_chk();

    // SUB equal operands, JC not taken, JZ taken to 0x1C.
    clear_all();
    prog[0] = mk(4'h1, 10); prog[1] = mk(4'h4, 11); prog[2] = mk(4'h9, 30);
    prog[3] = mk(4'h8, 28); prog[28] = mk(4'h2, 12); prog[29] = mk(4'h0, 0);
    ram[10] = 8'h55; ram[11] = 8'h55; ram[12] = 8'hAA;
    fetch_exp = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd28, 5'd29};
    wr_exp.push_back('{a: 5'd12, d: 8'h00});
    release_rst();
    wait_halt(n);
    check("t2_zero", 32'(zero), 32'd1);
    check("t2_carry", 32'(carry), 32'd0);
    check("t2_acc", 32'(mem_data_out), 32'd0);
    end_chk();

    // LDA with mem_ready low for 3 cycles.
    clear_all();
    prog[0] = mk(4'h1, 7); prog[1] = mk(4'h0, 0);
    ram[7] = 8'hA5;
    stall_left = 3;
    fetch_exp = '{5'd0, 5'd1};
    release_rst();
    wait_halt(n);
    check("t3_rd_cycles", 32'(rd_cycles), 32'd4);
    check("t3_acc_updates", 32'(acc_chg), 32'd1);
    check("t3_acc", 32'(mem_data_out), 32'hA5);
    check("t3_fetches", 32'(fetch_t.size()), 32'd2);
    if (fetch_t.size() >= 2) check("t3_instr_len", 32'(fetch_t[1] - fetch_t[0]), 32'd7);
    end_chk();

    // Four nested CALLs then four RETs.
    clear_all();
    prog[0] = mk(4'hA, 8); prog[8] = mk(4'hA, 16); prog[16] = mk(4'hA, 24);
    prog[24] = mk(4'hA, 28); prog[28] = mk(4'hB, 0); prog[25] = mk(4'hB, 0);
    prog[17] = mk(4'hB, 0); prog[9] = mk(4'hB, 0); prog[1] = mk(4'h0, 0);
    fetch_exp = '{5'd0, 5'd8, 5'd16, 5'd24, 5'd28, 5'd25, 5'd17, 5'd9, 5'd1};
    release_rst();
    wait_halt(n);
    check("t4_stk_err", 32'(stk_err), 32'd0);
    end_chk();

    // Fifth nested CALL overflows the stack.
    clear_all();
    prog[0] = mk(4'hA, 2); prog[2] = mk(4'hA, 4); prog[4] = mk(4'hA, 6);
    prog[6] = mk(4'hA, 8); prog[8] = mk(4'hA, 10);
    fetch_exp = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd8};
    release_rst();
    wait_halt(n);
    check("t5_stk_err", 32'(stk_err), 32'd1);
    check("t5_pc", 32'(prom_addr_out), 32'd9);
    check("t5_prom_rd", 32'(prom_rd), 32'd0);
    end_chk();

    // RET on an empty stack.
    clear_all();
    prog[0] = mk(4'hB, 0);
    fetch_exp = '{5'd0};
    release_rst();
    wait_halt(n);
    check("t6_stk_err", 32'(stk_err), 32'd1);
    check("t6_pc", 32'(prom_addr_out), 32'd1);
    end_chk();

    // PC wrap from 0x1F to 0x00, plus an illegal opcode acting as NOP.
    clear_all();
    prog[0] = mk(4'h8, 3); prog[1] = mk(4'h1, 20); prog[2] = mk(4'h7, 31);
    prog[31] = mk(4'hC, 0); prog[3] = mk(4'hF, 0); prog[4] = mk(4'h0, 0);
    fetch_exp = '{5'd0, 5'd1, 5'd2, 5'd31, 5'd0, 5'd3, 5'd4};
    release_rst();
    wait_halt(n);
    check("t7_zero", 32'(zero), 32'd1);
    end_chk();

    // Reset asserted while a write waits on mem_ready.
    clear_all();
    prog[0] = mk(4'h2, 6); prog[1] = mk(4'h0, 0);
    ram[6] = 8'h77;
    stall_left = 20;
    fetch_exp = '{5'd0};
    release_rst();
    n = 0;
    while (!mem_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t8_memwr_seen", 32'(mem_wr), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t8_memwr_drop", 32'(mem_wr), 32'd0);
    check("t8_prom_rd", 32'(prom_rd), 32'd0);
    check("t8_mem_rd", 32'(mem_rd), 32'd0);
    check("t8_halted", 32'(halted), 32'd0);
    check("t8_flags", 32'({zero, carry, stk_err}), 32'd0);
    check("t8_ram_kept", 32'(ram[6]), 32'h77);
    stall_left = 0;
    fetch_exp = '{5'd0, 5'd1};
    wr_exp.push_back('{a: 5'd6, d: 8'h00});
    release_rst();
    wait_halt(n);
    end_chk();

    // Wide build: 0xFFFF + 0x0001 wraps to zero with carry.
    prog16[0] = {4'h1, 8'h40}; prog16[1] = {4'h3, 8'h41};
    prog16[2] = {4'h2, 8'h42}; prog16[3] = {4'h0, 8'h00};
    ram16[8'h40] = 16'hFFFF; ram16[8'h41] = 16'h0001; ram16[8'h42] = 16'hBEEF;
    @(negedge clk);
    rst16 = 1'b1;
    n = 0;
    while (!h16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w_halted", 32'(h16), 32'd1);
    check("w_zero", 32'(z16), 32'd1);
    check("w_carry", 32'(c16), 32'd1);
    check("w_acc", 32'(mdo16), 32'd0);
    check("w_ram", 32'(ram16[8'h42]), 32'd0);
    check("w_stk_err", 32'(e16), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised successor to the team's 8-bit accumulator processor core. It fetches instructions from a program ROM, executes them against an accumulator, data memory, Z/C flags and a hardware return stack, and sits between the PROM and data-RAM wrappers at the top of the FPGA design. Four things are new:
- generic data and address width;
- ready/valid-style wait-state handshakes on both memories;
- a carry flag with conditional branches;
- CALL/RET with stack-error halt.

## Interface
Parameters:
- DW, 8, data/accumulator width (≥4)
- AW, 5, program and data address width; instruction word is 4+AW bits (opcode in [AW+3:AW], operand address in [AW-1:0])
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- prom_addr_out  out  AW  program counter
- prom_rd  out  1  instruction fetch request
- prom_ready  in  1  fetch complete; prom_data_in valid this cycle
- prom_data_in  in  4+AW  instruction word
- mem_addr_out  out  AW  data address (IR operand field)
- mem_rd  out  1  data read request
- mem_wr  out  1  data write request
- mem_ready  in  1  data access complete this cycle
- mem_data_in  in  DW  read data
- mem_data_out  out  DW  write data (= ACC)
- zero  out  1  Z flag
- carry  out  1  C flag
- halted  out  1  core stopped
- stk_err  out  1  stack overflow/underflow trap (sticky)

## Operation
Opcodes:
- 0 HLT
- 1 LDA: ACC←M
- 2 STA: M←ACC
- 3 ADD
- 4 SUB
- 5 AND
- 6 XOR
- 7 JMP
- 8 JZ
- 9 JC
- A CALL
- B RET
- C NOP
- D–F illegal, executed as NOP

Arithmetic and flags:
- ADD/SUB are DW-bit. C = carry-out for ADD, borrow for SUB (ACC<M unsigned).
- Z = (result==0). Z updates on LDA/ADD/SUB/AND/XOR.
- C updates on ADD/SUB only; AND/XOR leave C unchanged.

Program counter:
- PC increments modulo 2^AW; 2^AW−1 wraps to 0.
- JMP/CALL/taken branches load the IR operand.

Stack:
- CALL pushes the already-incremented PC.
- RET pops into PC.

States:
- BOOT: reset state, one idle cycle → FETCH.
- FETCH: prom_rd=1 held until prom_ready. On that edge, IR←prom_data_in and PC←PC+1 → DECODE.
- DECODE, by opcode:
  - HLT → HALT
  - JMP/JZ/JC/CALL/RET/NOP/illegal complete here → FETCH
  - LDA/ADD/SUB/AND/XOR → MEMRD
  - STA → MEMWR
- MEMRD: mem_rd=1 held until mem_ready; MDR latched on that edge → EXEC.
- EXEC: ACC/flags update → FETCH.
- MEMWR: mem_wr=1 held until mem_ready → FETCH.
- HALT: terminal until reset; halted=1.

Stack boundaries:
- CALL with stack full (STACK_DEPTH entries): no push, PC not loaded, stk_err←1 → HALT.
- RET with stack empty: stk_err←1 → HALT.

## Timing
- Reset values (asynchronous, while reset=0): PC=0, ACC=0, IR=0, Z=0, C=0, stack empty, state BOOT. All request outputs 0; halted=0, stk_err=0.
- The first fetch request appears in the 2nd cycle after reset release.
- Request/address outputs decode from state and registers only (no combinational path from ready).
- Address is stable for the whole request. Access completes on the clock edge where ready=1; ready while no request is ignored.
- Instruction length with zero-wait memories (ready tied high):
  - 2 cycles: JMP/Jcc/CALL/RET/NOP
  - 3 cycles: STA
  - 4 cycles: LDA/ALU ops
  - Each ready-low cycle adds one.
- Jcc decision uses flags as of DECODE, which always already reflect the previous instruction.
- mem_rd and mem_wr are never both 1; prom_rd is never concurrent with either.
- Reset mid-access drops requests immediately; an outstanding memory transaction is abandoned.

## Structure
- Package acc_cpu_pkg holds:
  - the 4-bit opcode enum;
  - the state enum (BOOT, FETCH, DECODE, MEMRD, EXEC, MEMWR, HALT);
  - width helper localparams (IW=4+AW, SPW=$clog2(STACK_DEPTH)+1).
- One sub-module, acc_ret_stack: push/pop/full/empty, AW-bit entries, async active-low reset.
- The ALU stays combinational inside the core.

## Test plan
- DW=8, AW=5, ready tied high; program LDA 3, ADD 4, STA 5, HLT with M[3]=0xF0, M[4]=0x20 → M[5]=0x10, C=1, Z=0. halted asserts after 4+4+3+2=13 cycles from the first FETCH.
- SUB equal operands: ACC=0x55, M=0x55 → ACC=0, Z=1, C=0. Following JZ 0x1C → prom_addr_out=0x1C on the next fetch; JC not taken.
- mem_ready held low 3 cycles during LDA → mem_rd high 4 cycles with stable mem_addr_out; ACC updates once; total instruction 7 cycles.
- Nested CALLs, STACK_DEPTH=4: 4 nested CALLs then 4 RETs return correctly. A 5th CALL → stk_err=1, halted=1, PC unchanged. RET on empty stack from a fresh reset also traps.
- PC at 0x1F executing NOP → next fetch address 0x00. DW=16, AW=8 build: ADD 0xFFFF+0x0001 → ACC=0, C=1, Z=1.
- Assert reset during MEMWR wait → mem_wr drops the same cycle. After release: PC=0, outputs at reset values, BOOT then FETCH.
